// File: rtl/dmem_core_arbiter_pkg.sv
// Shared types and constants for the multi-core data-memory arbiter.
// Also holds the LR/SC funct5 codes that the atomic unit decodes.
package dmem_arb_pkg;

  localparam int AMO_TYPE_W = 5;

  localparam logic [AMO_TYPE_W-1:0] AMO_LR = 5'b00010;
  localparam logic [AMO_TYPE_W-1:0] AMO_SC = 5'b00011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_core_arbiter_if.sv
// Core-side and atomic-unit-side request/response bundle of the arbiter.
// slave = arbiter view, master = environment (cores + atomic unit) view.
interface dmem_core_arbiter_if #(
  parameter int N      = 2,
  parameter int XLEN   = 32,
  parameter int CBSIZE = 256
);
  import dmem_arb_pkg::*;

  logic [N-1:0]            cores_strobe_i;
  logic [N*XLEN-1:0]       cores_addr_i;
  logic [N-1:0]            cores_rw_i;
  logic [N*CBSIZE-1:0]     cores_data_i;
  logic [N-1:0]            cores_is_amo_i;
  logic [N*AMO_TYPE_W-1:0] cores_amo_type_i;
  logic [N-1:0]            cores_done_o;
  logic [CBSIZE-1:0]       cores_data_o;

  logic [N-1:0]            au_core_id_o;
  logic                    au_strobe_o;
  logic [XLEN-1:0]         au_addr_o;
  logic                    au_rw_o;
  logic [CBSIZE-1:0]       au_data_o;
  logic                    au_is_amo_o;
  logic [AMO_TYPE_W-1:0]   au_amo_type_o;
  logic                    au_done_i;
  logic [CBSIZE-1:0]       au_data_i;

  modport slave (
    input  cores_strobe_i, cores_addr_i, cores_rw_i, cores_data_i,
    input  cores_is_amo_i, cores_amo_type_i, au_done_i, au_data_i,
    output cores_done_o, cores_data_o, au_core_id_o, au_strobe_o,
    output au_addr_o, au_rw_o, au_data_o, au_is_amo_o, au_amo_type_o
  );

  modport master (
    output cores_strobe_i, cores_addr_i, cores_rw_i, cores_data_i,
    output cores_is_amo_i, cores_amo_type_i, au_done_i, au_data_i,
    input  cores_done_o, cores_data_o, au_core_id_o, au_strobe_o,
    input  au_addr_o, au_rw_o, au_data_o, au_is_amo_o, au_amo_type_o
  );

endinterface

// File: rtl/dmem_core_arbiter_rr_pick.sv
// Combinational round-robin pick: first set pending bit at or after rr_ptr_i,
// wrapping; returns both one-hot and binary forms of the winner.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [PW-1:0] grant_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_i) + k) % N;
      if (!found && pending_i[idx]) begin
        found           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/dmem_core_arbiter.sv
// Round-robin arbiter funnelling N cores' data-memory requests into the single
// atomic-unit port; request fields are held from ISSUE through RESP.
module dmem_core_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N      = 2,
  parameter int XLEN   = 32,
  parameter int CBSIZE = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_core_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_e                state_q, state_d;
  logic [N-1:0]          pending_q, pending_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [N-1:0]          au_id_q, au_id_d;
  logic [XLEN-1:0]       au_addr_q, au_addr_d;
  logic                  au_rw_q, au_rw_d;
  logic [CBSIZE-1:0]     au_data_q, au_data_d;
  logic                  au_is_amo_q, au_is_amo_d;
  logic [AMO_TYPE_W-1:0] au_type_q, au_type_d;
  logic [N-1:0]          done_q, done_d;
  logic [CBSIZE-1:0]     rdata_q, rdata_d;
  logic                  au_strobe;

  logic [N-1:0]          pick_oh;
  logic [PW-1:0]         pick_idx;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .pending_i   (pending_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = ISSUE;
      ISSUE:   state_d = bus.au_done_i ? RESP : WAIT;
      WAIT:    if (bus.au_done_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    au_strobe = (state_q == ISSUE);
  end

  // Datapath next-state; au_done_i only matters while a request is outstanding.
  always_comb begin
    pending_d   = (pending_q & ((state_q == RESP) ? ~au_id_q : '1)) | bus.cores_strobe_i;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    au_id_d     = au_id_q;
    au_addr_d   = au_addr_q;
    au_rw_d     = au_rw_q;
    au_data_d   = au_data_q;
    au_is_amo_d = au_is_amo_q;
    au_type_d   = au_type_q;
    done_d      = '0;
    rdata_d     = '0;

    if (state_q == IDLE && |pending_q) begin
      grant_d     = pick_idx;
      au_id_d     = pick_oh;
      au_addr_d   = bus.cores_addr_i[pick_idx*XLEN +: XLEN];
      au_rw_d     = bus.cores_rw_i[pick_idx];
      au_data_d   = bus.cores_data_i[pick_idx*CBSIZE +: CBSIZE];
      au_is_amo_d = bus.cores_is_amo_i[pick_idx];
      au_type_d   = bus.cores_amo_type_i[pick_idx*AMO_TYPE_W +: AMO_TYPE_W];
    end

    if ((state_q == ISSUE || state_q == WAIT) && bus.au_done_i) begin
      done_d  = au_id_q;
      rdata_d = bus.au_data_i;
    end

    if (state_q == RESP) begin
      rr_ptr_d = (grant_q == PW'(N - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      au_id_q     <= '0;
      au_addr_q   <= '0;
      au_rw_q     <= 1'b0;
      au_data_q   <= '0;
      au_is_amo_q <= 1'b0;
      au_type_q   <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      au_id_q     <= au_id_d;
      au_addr_q   <= au_addr_d;
      au_rw_q     <= au_rw_d;
      au_data_q   <= au_data_d;
      au_is_amo_q <= au_is_amo_d;
      au_type_q   <= au_type_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.au_strobe_o   = au_strobe;
  assign bus.au_core_id_o  = au_id_q;
  assign bus.au_addr_o     = au_addr_q;
  assign bus.au_rw_o       = au_rw_q;
  assign bus.au_data_o     = au_data_q;
  assign bus.au_is_amo_o   = au_is_amo_q;
  assign bus.au_amo_type_o = au_type_q;
  assign bus.cores_done_o  = done_q;
  assign bus.cores_data_o  = rdata_q;

endmodule

// File: tb/tb_dmem_core_arbiter.sv
// Directed bench for dmem_core_arbiter (N=2): inputs driven 1ns after the
// rising edge, outputs checked at the same point with immediate assertions.
module tb_dmem_core_arbiter;

  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  logic [255:0] d_c0   = {8{32'h0000_C0DE}};
  logic [255:0] d_c1   = {8{32'h1111_CAFE}};
  logic [255:0] d_a5   = {32{8'hA5}};
  logic [255:0] d_amo  = {8{32'h0000_0042}};
  logic [255:0] d_r1   = {8{32'h1234_5678}};
  logic [255:0] d_r2   = {8{32'h9ABC_DEF0}};
  logic [255:0] d_zero = {8{32'h0BAD_F00D}};

  dmem_core_arbiter_if #(.N(2), .XLEN(32), .CBSIZE(256)) bus ();

  dmem_core_arbiter #(.N(2), .XLEN(32), .CBSIZE(256)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance until the atomic-unit strobe appears (bounded), then check the grant.
  task automatic issue_wait(input logic [1:0] exp_id, input string tag);
    int n;
    n = 0;
    while (bus.au_strobe_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_strobe"}, 256'(bus.au_strobe_o), 256'(1'b1));
    chk({tag, "_id"}, 256'(bus.au_core_id_o), 256'(exp_id));
  endtask

  // From the ISSUE cycle: done after lat cycles; returns in the RESP cycle.
  task automatic respond(input int lat, input logic [255:0] d, input logic [1:0] exp_id,
                         input string tag);
    repeat (lat) step();
    bus.au_done_i = 1'b1;
    bus.au_data_i = d;
    step();
    bus.au_done_i = 1'b0;
    bus.au_data_i = '0;
    chk({tag, "_done"}, 256'(bus.cores_done_o), 256'(exp_id));
    chk({tag, "_rdata"}, bus.cores_data_o, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                = 1'b0;
    bus.cores_strobe_i   = '0;
    bus.cores_addr_i     = '0;
    bus.cores_rw_i       = '0;
    bus.cores_data_i     = {d_c1, d_c0};
    bus.cores_is_amo_i   = '0;
    bus.cores_amo_type_i = '0;
    bus.au_done_i        = 1'b0;
    bus.au_data_i        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 256'(bus.cores_done_o), 256'(0));
    chk("rst_strobe", 256'(bus.au_strobe_o), 256'(0));
    chk("rst_id", 256'(bus.au_core_id_o), 256'(0));
    chk("rst_rdata", bus.cores_data_o, 256'(0));
    rst_n = 1'b1;
    step();

    // Single plain read from core0, downstream answers 3 cycles after issue.
    bus.cores_addr_i[31:0] = 32'h8000_0010;
    bus.cores_strobe_i     = 2'b01;
    step();
    bus.cores_strobe_i = 2'b00;
    chk("rd_no_early_strobe", 256'(bus.au_strobe_o), 256'(0));
    step();
    chk("rd_strobe", 256'(bus.au_strobe_o), 256'(1));
    chk("rd_id", 256'(bus.au_core_id_o), 256'(2'b01));
    chk("rd_addr", 256'(bus.au_addr_o), 256'(32'h8000_0010));
    chk("rd_rw", 256'(bus.au_rw_o), 256'(0));
    chk("rd_wdata", bus.au_data_o, d_c0);
    step();
    chk("rd_strobe_one_cycle", 256'(bus.au_strobe_o), 256'(0));
    chk("rd_id_hold", 256'(bus.au_core_id_o), 256'(2'b01));
    respond(2, d_a5, 2'b01, "rd");
    step();
    chk("rd_done_clear", 256'(bus.cores_done_o), 256'(0));
    chk("rd_rdata_clear", bus.cores_data_o, 256'(0));

    // AMO from core1 held across a 6-cycle downstream sequence.
    bus.cores_addr_i[63:32]   = 32'h0000_0100;
    bus.cores_rw_i            = 2'b10;
    bus.cores_is_amo_i        = 2'b10;
    bus.cores_amo_type_i[9:5] = 5'b00000;
    bus.cores_strobe_i        = 2'b10;
    step();
    bus.cores_strobe_i = 2'b00;
    issue_wait(2'b10, "amo");
    chk("amo_addr", 256'(bus.au_addr_o), 256'(32'h100));
    chk("amo_wdata", bus.au_data_o, d_c1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("amo_hold_strobe", 256'(bus.au_strobe_o), 256'(0));
      chk("amo_hold_isamo", 256'(bus.au_is_amo_o), 256'(1));
      chk("amo_hold_type", 256'(bus.au_amo_type_o), 256'(0));
      chk("amo_hold_id", 256'(bus.au_core_id_o), 256'(2'b10));
      chk("amo_no_done", 256'(bus.cores_done_o), 256'(0));
    end
    respond(0, d_amo, 2'b10, "amo");
    bus.cores_is_amo_i = 2'b00;
    bus.cores_rw_i     = 2'b00;
    step();
    chk("amo_single_done", 256'(bus.cores_done_o), 256'(0));

    // Simultaneous strobes with rr_ptr = 0: core0 then core1.
    bus.cores_strobe_i = 2'b11;
    step();
    bus.cores_strobe_i = 2'b00;
    issue_wait(2'b01, "sim0_a");
    respond(1, d_r1, 2'b01, "sim0_a");
    step();
    issue_wait(2'b10, "sim0_b");
    respond(1, d_r2, 2'b10, "sim0_b");
    step();
    chk("sim0_rrptr", 256'(dut.rr_ptr_q), 256'(0));

    // Zero-latency downstream: strobe at t, issue at t+2, done at t+3.
    bus.cores_strobe_i = 2'b01;
    step();
    bus.cores_strobe_i = 2'b00;
    chk("zl_t1_strobe", 256'(bus.au_strobe_o), 256'(0));
    step();
    chk("zl_t2_strobe", 256'(bus.au_strobe_o), 256'(1));
    chk("zl_t2_id", 256'(bus.au_core_id_o), 256'(2'b01));
    respond(0, d_zero, 2'b01, "zl_t3");
    step();

    // Simultaneous strobes with rr_ptr = 1: core1 then core0.
    bus.cores_strobe_i = 2'b11;
    step();
    bus.cores_strobe_i = 2'b00;
    issue_wait(2'b10, "sim1_a");
    respond(2, d_r2, 2'b10, "sim1_a");
    step();
    issue_wait(2'b01, "sim1_b");
    respond(0, d_r1, 2'b01, "sim1_b");
    step();
    chk("sim1_rrptr", 256'(dut.rr_ptr_q), 256'(1));

    // Core0 re-strobes in its own RESP cycle while core1 is pending.
    bus.cores_strobe_i = 2'b01;
    step();
    bus.cores_strobe_i = 2'b00;
    issue_wait(2'b01, "b2b_a");
    step();
    bus.cores_strobe_i = 2'b10;
    step();
    bus.cores_strobe_i = 2'b00;
    respond(1, d_r1, 2'b01, "b2b_a");
    bus.cores_strobe_i = 2'b01;
    step();
    bus.cores_strobe_i = 2'b00;
    chk("b2b_gap_done", 256'(bus.cores_done_o), 256'(0));
    issue_wait(2'b10, "b2b_b");
    respond(2, d_r2, 2'b10, "b2b_b");
    step();
    issue_wait(2'b01, "b2b_c");
    respond(0, d_zero, 2'b01, "b2b_c");
    step();

    // Asynchronous reset while in WAIT.
    bus.cores_strobe_i = 2'b01;
    step();
    bus.cores_strobe_i = 2'b00;
    issue_wait(2'b01, "arst_pre");
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_strobe", 256'(bus.au_strobe_o), 256'(0));
    chk("arst_id", 256'(bus.au_core_id_o), 256'(0));
    chk("arst_addr", 256'(bus.au_addr_o), 256'(0));
    chk("arst_wdata", bus.au_data_o, 256'(0));
    chk("arst_done", 256'(bus.cores_done_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.au_done_i = 1'b1;
    bus.au_data_i = d_a5;
    step();
    bus.au_done_i = 1'b0;
    bus.au_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      chk("post_arst_strobe", 256'(bus.au_strobe_o), 256'(0));
      chk("post_arst_done", 256'(bus.cores_done_o), 256'(0));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
